// File: rtl/tp_cbus_req_queue.sv
// Host-to-cbus request queue: buffers read/write requests in strict FIFO order,
// presents the head to the downstream arbiter and returns read data one cycle after memory.
module tp_cbus_req_queue #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int DEPTH     = 4,
  parameter int STALL_MAX = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_req,
  input  logic          host_cmd,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wrdata,
  output logic          host_ack,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          cbus_req,
  output logic          cbus_cmd,
  output logic [AW-1:0] cbus_addr,
  output logic [DW-1:0] cbus_wrdata,
  input  logic          cbus_waccept,
  input  logic          cbus_rresp,
  input  logic [DW-1:0] mem_rdata,
  output logic          full,
  output logic          busy,
  output logic          stall_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);

  logic          cmd_mem  [DEPTH];
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          empty;
  logic          push;
  logic          pop;
  logic          head_cmd;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign wr_idx = wr_ptr_q[IW-1:0];
  assign rd_idx = rd_ptr_q[IW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);

  // Acceptance depends only on the current fullness; a same-cycle pop never frees a slot early.
  assign host_ack = host_req & ~full;
  assign push     = host_ack;

  assign head_cmd = cmd_mem[rd_idx];
  assign pop      = ~empty & ((cbus_waccept & ~head_cmd) | (cbus_rresp & head_cmd));

  assign cbus_req    = ~empty;
  assign cbus_cmd    = empty ? 1'b0      : head_cmd;
  assign cbus_addr   = empty ? '0        : addr_mem[rd_idx];
  assign cbus_wrdata = empty ? '0        : data_mem[rd_idx];

  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_q;
  assign busy        = ~empty | rd_pend_q;
  assign stall_err   = (stall_q == STALL_LIM);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    stall_d   = stall_q;
    rd_pend_d = pop & head_cmd;
    rvalid_d  = rd_pend_q;
    rdata_d   = rdata_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (rd_pend_q) rdata_d = mem_rdata;
    // Counts head-wait cycles; saturates so stall_err stays up until the head finally moves.
    if (empty || pop)          stall_d = '0;
    else if (stall_q != STALL_LIM) stall_d = stall_q + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      stall_q   <= '0;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      stall_q   <= stall_d;
      rd_pend_q <= rd_pend_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  // Entry storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_idx]  <= host_cmd;
      addr_mem[wr_idx] <= host_addr;
      data_mem[wr_idx] <= host_cmd ? '0 : host_wrdata;
    end
  end

endmodule

// File: tb/tb_tp_cbus_req_queue.sv
// Self-checking bench for tp_cbus_req_queue: directed scenarios plus random traffic,
// all compared each cycle against a queue-based reference model.
module tb_tp_cbus_req_queue;

  localparam int DW        = 32;
  localparam int AW        = 32;
  localparam int DEPTH     = 4;
  localparam int STALL_MAX = 255;
  localparam int EW        = 1 + AW + DW;

  logic          clk;
  logic          rst;
  logic          host_req;
  logic          host_cmd;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wrdata;
  logic          host_ack;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          cbus_req;
  logic          cbus_cmd;
  logic [AW-1:0] cbus_addr;
  logic [DW-1:0] cbus_wrdata;
  logic          cbus_waccept;
  logic          cbus_rresp;
  logic [DW-1:0] mem_rdata;
  logic          full;
  logic          busy;
  logic          stall_err;

  tp_cbus_req_queue #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_cmd(host_cmd), .host_addr(host_addr),
    .host_wrdata(host_wrdata), .host_ack(host_ack),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .cbus_req(cbus_req), .cbus_cmd(cbus_cmd), .cbus_addr(cbus_addr),
    .cbus_wrdata(cbus_wrdata), .cbus_waccept(cbus_waccept),
    .cbus_rresp(cbus_rresp), .mem_rdata(mem_rdata),
    .full(full), .busy(busy), .stall_err(stall_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model state
  logic [EW-1:0] exp_q[$];
  bit            m_rd_pend;
  bit            m_rvalid;
  logic [DW-1:0] m_rdata;
  int            m_stall;

  int n_checks;
  int n_errors;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rd_pend = 0;
    m_rvalid  = 0;
    m_rdata   = '0;
    m_stall   = 0;
  endtask

  task automatic check_outputs();
    bit            ne;
    logic [EW-1:0] h;
    ne = (exp_q.size() > 0);
    h  = ne ? exp_q[0] : '0;
    check_val("cbus_req",    cbus_req,    ne);
    check_val("cbus_cmd",    cbus_cmd,    h[EW-1]);
    check_val("cbus_addr",   cbus_addr,   h[AW+DW-1:DW]);
    if (!h[EW-1]) check_val("cbus_wrdata", cbus_wrdata, h[DW-1:0]);
    check_val("full",        full,        exp_q.size() == DEPTH);
    check_val("busy",        busy,        ne || m_rd_pend);
    check_val("stall_err",   stall_err,   m_stall == STALL_MAX);
    check_val("host_rvalid", host_rvalid, m_rvalid);
    check_val("host_rdata",  host_rdata,  m_rdata);
  endtask

  // driver: called at a falling edge; checks state, drives one cycle, advances the model
  task automatic cyc(input bit req, input bit cmd, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input bit wacc, input bit rresp,
                     input logic [DW-1:0] md);
    bit exp_ack;
    bit pop;
    bit head_rd;
    check_outputs();
    host_req     = req;
    host_cmd     = cmd;
    host_addr    = addr;
    host_wrdata  = wd;
    cbus_waccept = wacc;
    cbus_rresp   = rresp;
    mem_rdata    = md;
    #1;
    exp_ack = req && (exp_q.size() < DEPTH);
    check_val("host_ack", host_ack, exp_ack);
    head_rd = (exp_q.size() > 0) && exp_q[0][EW-1];
    pop     = (exp_q.size() > 0) && (head_rd ? rresp : wacc);
    if (m_rd_pend) begin
      m_rdata  = md;
      m_rvalid = 1;
    end else begin
      m_rvalid = 0;
    end
    if (pop || exp_q.size() == 0) m_stall = 0;
    else if (m_stall < STALL_MAX) m_stall++;
    m_rd_pend = pop && head_rd;
    if (pop) void'(exp_q.pop_front());
    if (exp_ack) exp_q.push_back({cmd, addr, wd});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, 0, $urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() > 0 || m_rd_pend || m_rvalid) && k < 50) begin
      cyc(0, 0, '0, '0, 1, 1, $urandom);
      k++;
    end
    check_val("drain_done", exp_q.size() + int'(m_rd_pend) + int'(m_rvalid), 0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    host_req     = 0;
    host_cmd     = 0;
    host_addr    = '0;
    host_wrdata  = '0;
    cbus_waccept = 0;
    cbus_rresp   = 0;
    mem_rdata    = '0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // single write: appears next cycle, waccept retires it
    cyc(1, 0, 32'h10, 32'hA5A5A5A5, 0, 0, '0);
    cyc(0, 0, '0, '0, 1, 0, '0);
    idle(1);
    check_val("write_retired_busy", busy, 0);

    // single read: return data two cycles after rresp
    cyc(1, 1, 32'h20, '0, 0, 0, '0);
    cyc(0, 0, '0, '0, 0, 1, '0);
    cyc(0, 0, '0, '0, 0, 0, 32'h12345678);
    check_val("rd_return_valid", host_rvalid, 1);
    check_val("rd_return_data",  host_rdata,  32'h12345678);
    idle(2);

    // fill, refuse 5th, refuse push during pop while full
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 32'h100 + i, $urandom, 0, 0, '0);
    cyc(1, 0, 32'h200, 32'h1, 0, 0, '0);
    cyc(1, 0, 32'h201, 32'h2, 1, 0, '0);
    check_val("occupancy_after_full_pop", full, 0);
    drain();

    // stall on an unanswered read head
    cyc(1, 1, 32'h30, '0, 0, 0, '0);
    idle(STALL_MAX);
    check_val("stall_err_set", stall_err, 1);
    idle(3);
    check_val("stall_err_hold", stall_err, 1);
    cyc(0, 0, '0, '0, 0, 1, '0);
    check_val("stall_err_clear", stall_err, 0);
    idle(2);

    // mismatched accept is ignored; reset drops the pending return
    cyc(1, 1, 32'h40, '0, 0, 0, '0);
    cyc(0, 0, '0, '0, 1, 0, '0);
    check_val("mismatch_head_kept", cbus_addr, 32'h40);
    cyc(0, 0, '0, '0, 0, 1, '0);
    do_reset();
    idle(3);
    check_val("no_rvalid_after_rst", host_rvalid, 0);

    // back-to-back reads
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h50 + i, '0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 0, 1, $urandom);
    idle(3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom, $urandom,
          $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40, $urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tp_cbus_req_queue.md
TP_CBUS_REQ_QUEUE -- requirements
Module: tp_cbus_req_queue

Interface
REQ-001 Parameters SHALL be: DW, default 32, data width; AW, default 32, address width; DEPTH, default 4, queue entries (power of 2, >=2); STALL_MAX, default 255, head-wait cycles before stall_err.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high, with ports named clk and rst.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 host_req  input  1  host offers a transaction this cycle.
REQ-006 host_cmd  input  1  1 = read, 0 = write.
REQ-007 host_addr  input  AW  transaction address.
REQ-008 host_wrdata  input  DW  write data; ignored for reads.
REQ-009 host_ack  output  1  transaction accepted into queue this cycle.
REQ-010 host_rvalid  output  1  one-cycle pulse, host_rdata valid.
REQ-011 host_rdata  output  DW  read return data.
REQ-012 cbus_req / cbus_cmd / cbus_addr / cbus_wrdata  output  1/1/AW/DW  head-of-queue request to the downstream two-port arbiter.
REQ-013 cbus_waccept  input  1  arbiter accepted head write this cycle.
REQ-014 cbus_rresp  input  1  arbiter accepted head read this cycle.
REQ-015 mem_rdata  input  DW  memory read data, valid exactly 1 cycle after cbus_rresp.
REQ-016 full / busy / stall_err  output  1 each  queue full; queue non-empty or read return pending; head waited STALL_MAX cycles.

Function
REQ-017 host_ack SHALL equal host_req & ~full (combinational); no bypass, a push into a full queue is refused even if a pop occurs the same cycle.
REQ-018 On host_ack the entry {cmd, addr, wrdata} SHALL be written at the write pointer; pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-019 full SHALL assert when pointers differ only in MSB; empty when equal.
REQ-020 cbus_req SHALL equal ~empty; cbus_cmd/addr/wrdata SHALL be driven from the head entry, all-zero when empty.
REQ-021 An entry pushed into an empty queue SHALL appear on cbus_req the following cycle (1-cycle min latency).
REQ-022 Pop SHALL occur when (cbus_waccept & ~head_cmd) | (cbus_rresp & head_cmd) while non-empty; mismatched or empty-queue accepts SHALL be ignored.
REQ-023 Simultaneous push and pop on a non-full queue SHALL both take effect; occupancy unchanged.
REQ-024 Issue order SHALL be strict FIFO; reads and writes never reorder.
REQ-025 A read pop SHALL set rd_pend; the next cycle host_rdata SHALL capture mem_rdata and host_rvalid SHALL pulse for 1 cycle; host_rdata holds its value until the next return.
REQ-026 Back-to-back read pops on consecutive cycles SHALL produce back-to-back host_rvalid pulses.
REQ-027 Stall counter SHALL count cycles with cbus_req high and no pop, clear on pop or empty, saturate at STALL_MAX; stall_err = (count == STALL_MAX), cleared with the counter.
REQ-028 busy SHALL equal ~empty | rd_pend.

Reset
REQ-029 On rst asserted, pointers, rd_pend, stall counter, host_rdata SHALL go to 0 immediately; host_rvalid, cbus_req, full, busy, stall_err SHALL be 0; queued entries are discarded.
REQ-030 A read return pending when rst asserts SHALL be dropped (no host_rvalid after release).
REQ-031 First push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-032 Push write addr 0x10 data 0xA5A5A5A5 into empty queue -> cbus_req=1, cbus_cmd=0, cbus_addr=0x10 next cycle; waccept 1 cycle -> cbus_req=0, busy=0.
REQ-033 Push read 0x20, rresp at cycle t, mem_rdata=0x12345678 at t+1 -> host_rvalid=1 and host_rdata=0x12345678 at t+2 only.
REQ-034 Push 4 entries with no accepts -> full=1, 5th host_req gets host_ack=0; pop+push same cycle while full -> push refused, occupancy 3 after.
REQ-035 Hold read at head with no rresp for 255 cycles -> stall_err=1 and stays; rresp -> stall_err=0 next cycle.
REQ-036 Assert waccept while head is a read -> no pop, head unchanged; assert rst between rresp and return -> no host_rvalid, all outputs 0.
